// File: rtl/imem_loader_if.sv
// Host byte link, instruction-memory write port and core-control signals of the imem_loader.
// The slave modport is the loader side; the master modport is the host/system side.
interface imem_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              start;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    modport slave (
        input  in_valid, in_data, start,
        output in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, error, words_loaded
    );

    modport master (
        output in_valid, in_data, start,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte image into instruction memory and holds the core in reset meanwhile.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int MAX_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK   = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_byte_cnt;
    logic [15:0]       r_len;
    logic [15:0]       r_idx;
    logic [23:0]       r_shift;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_cpu_rst_n;
    logic              r_done;
    logic              r_error;
    logic              r_busy;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic              w_in_ready;
    logic              w_accept;
    logic [31:0]       w_word;
    logic [15:0]       w_len_new;
    logic              w_last;
    logic              w_rearm;

    always_comb begin
        w_in_ready = (r_state == S_LEN) || (r_state == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_in_ready = w_in_ready || (r_state == S_CHK);
`endif
    end

    assign w_accept  = bus.in_valid & w_in_ready;
    assign w_word    = {r_shift, bus.in_data};
    assign w_len_new = {r_len[7:0], bus.in_data};
    assign w_last    = ((r_idx + 16'd1) == r_len);
    assign w_rearm   = ((r_state == S_DONE) || (r_state == S_ERR)) && bus.start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN: begin
                if (w_accept && (r_byte_cnt == 2'd1)) begin
                    if (w_len_new == 16'd0)
                        w_next = S_FIN;
                    else if (w_len_new > MAX_N)
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_cnt == 2'd3))
                    w_next = S_WRITE;
            end
            S_WRITE: w_next = w_last ? S_FIN : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_accept)
                    w_next = (bus.in_data == r_xor) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (bus.start)
                    w_next = S_LEN;
            end
            default: w_next = S_LEN;
        endcase
    end

    // Status outputs follow the next state so they are registered yet aligned with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_LEN;
            r_byte_cnt  <= 2'd0;
            r_len       <= 16'd0;
            r_idx       <= 16'd0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 32'd0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_byte_cnt <= 2'd0;
            else if (w_accept)
                r_byte_cnt <= r_byte_cnt + 2'd1;
            if ((r_state == S_LEN) && w_accept)
                r_len <= w_len_new;
            if (w_rearm)
                r_idx <= 16'd0;
            else if (r_state == S_WRITE)
                r_idx <= r_idx + 16'd1;
            r_wr_en <= (w_next == S_WRITE);
            if ((r_state == S_DATA) && (w_next == S_WRITE)) begin
                r_wr_addr <= ADDR_W'({r_idx, 2'b00});
                r_wr_data <= w_word;
            end
            r_cpu_rst_n <= (w_next == S_DONE);
            r_done      <= (w_next == S_DONE);
            r_error     <= (w_next == S_ERR);
            r_busy      <= (w_next != S_DONE) && (w_next != S_ERR);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_xor <= 8'd0;
        else if (w_rearm)
            r_xor <= 8'd0;
        else if ((r_state == S_DATA) && w_accept)
            r_xor <= r_xor ^ bus.in_data;
    end
`endif

    // Partial words need no reset: a restart always refills all four bytes first.
    always_ff @(posedge clk) begin
        if ((r_state == S_DATA) && w_accept)
            r_shift <= w_word[23:0];
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.cpu_rst_n    = r_cpu_rst_n;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.words_loaded = r_idx;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the single-cycle core reads through its PC.
- Receives a byte stream from a host link (valid/ready), assembles big-endian 32-bit instruction words and writes them to consecutive word addresses starting at 0.
- Holds the core in reset while loading and releases it when the image is complete.
- Sits at top level between the host link, the instruction memory write port and the core reset.

Parameters:
- MAX_WORDS, 256, largest accepted image length in words; must be in 1..65535.
- ADDR_W, 32, width of wr_addr; matches the PC width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte; a byte is taken on an edge where in_valid and in_ready are both 1.
- start  in  1  one-cycle pulse that re-arms the loader from DONE or ERR.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  byte address of the word, always a multiple of 4.
- wr_data  out  32  instruction word.
- cpu_rst_n  out  1  core reset, active-low; 0 while loading.
- busy  out  1  1 in LEN, DATA, WRITE and CHK.
- done  out  1  1 in DONE.
- error  out  1  1 in ERR; sticky until start or reset.
- words_loaded  out  16  count of words written so far in the current load.

Behaviour:
- Frame format: 2-byte word count N (high byte first), then N words of 4 bytes each, MSB first.
- States: LEN, DATA, WRITE, CHK (only with the optional feature), DONE, ERR.
- Reset (reset = 0, asynchronous):
  - state = LEN, byte count = 0, word index = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0, words_loaded = 0.
  - cpu_rst_n = 0, done = 0, error = 0, busy = 1.
- in_ready = 1 only in LEN, DATA and CHK.
- LEN:
  - Accepts 2 bytes into N.
  - On the edge that accepts the 2nd byte:
    - N = 0 goes to DONE.
    - N > MAX_WORDS goes to ERR.
    - Otherwise goes to DATA.
- DATA:
  - Shifts accepted bytes into a 32-bit shift register, first byte landing in bits 31:24.
  - On the edge that accepts the 4th byte, goes to WRITE.
- WRITE:
  - Lasts exactly one cycle.
  - wr_en = 1, wr_addr = 4 × index, wr_data = assembled word; all three are registered and valid for that whole cycle.
  - At the end of the cycle, index and words_loaded increment.
  - If index + 1 = N, goes to DONE (or CHK when the feature is compiled in); otherwise returns to DATA.
- Latency: wr_en rises in the cycle after the 4th byte of a word is accepted.
- Throughput: at most one byte per cycle; 5 cycles per word minimum.
- DONE:
  - cpu_rst_n = 1, driven from a register; it rises in the first cycle in DONE.
  - busy = 0, done = 1.
  - Bytes are ignored (in_ready = 0).
- ERR:
  - cpu_rst_n stays 0, error = 1, no writes.
- start (in DONE or ERR):
  - Next state is LEN; index, byte count and words_loaded clear.
  - cpu_rst_n drops to 0 on the same edge.
  - start is ignored in other states.
- in_valid with in_ready = 0: the byte is not consumed; the host holds it.
- Reset mid-load: everything aborts immediately; partially assembled words are discarded, and memory contents already written are left as they are.
- wr_addr wraps modulo 2^ADDR_W; this cannot occur while MAX_WORDS ≤ 2^(ADDR_W-2).

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE the loader enters CHK and accepts one byte.
  - The byte must equal the XOR of all 4N data bytes; match goes to DONE, mismatch goes to ERR.
  - With N = 0, the checksum byte must be 0x00 and LEN goes to CHK instead of DONE.
- Not defined: the CHK state and the XOR accumulator are absent and the frame ends after the last word.

Test Plan:
- Reset released, send 00 01 20 08 00 05 -> one wr_en pulse with wr_addr = 0x0, wr_data = 0x20080005. That pulse is in the cycle after byte 6 is accepted. Next cycle done = 1 and cpu_rst_n = 1; words_loaded = 1.
- N = 3, words 0x00000001, 0x00000002, 0x00000003, in_valid gapped at random -> writes at addresses 0x0, 0x4, 0x8 with the matching data. in_ready is low exactly during each WRITE cycle. words_loaded = 3.
- With MAX_WORDS = 256, send header 01 01 (N = 257) -> error = 1, no wr_en, cpu_rst_n stays 0. A start pulse returns to LEN with error = 0.
- Header 00 00 -> DONE one cycle after the 2nd byte, no writes (feature off).
- Reset asserted after 2 bytes of the 2nd word of N = 2 -> all outputs reach their reset values immediately. A fresh frame of N = 1 then writes address 0x0 correctly.
- With IMEM_LOADER_CHECKSUM_EN, word 0x12345678 followed by checksum 0x08 -> DONE. The same word followed by checksum 0x09 -> ERR, cpu_rst_n = 0.
